pipeline_booth_multiplier_param: RTL and testbench



---
 rtl/pipeline_booth_pkg.sv | 32 +++
 rtl/pipeline_booth_multiplier_param_if.sv | 26 ++
 rtl/booth_acc_stage.sv | 84 ++++++++
 rtl/pipeline_booth_multiplier_param.sv | 98 +++++++++
 tb/tb_pipeline_booth_multiplier_param.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_booth_pkg.sv
// Shared definitions for the pipelined radix-4 Booth multiplier:
// Booth digit encoding, 3-bit recoder and pipeline depth helper.
package pipeline_booth_pkg;

  // Radix-4 Booth digit set {-2,-1,0,+1,+2}
  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } booth_dig_e;

  // Map {b[2j+1], b[2j], b[2j-1]} to a Booth digit
  function automatic booth_dig_e booth_recode(input logic [2:0] trip);
    booth_dig_e dig;
    case (trip)
      3'b001, 3'b010: dig = DIG_P1;
      3'b011:         dig = DIG_P2;
      3'b100:         dig = DIG_M2;
      3'b101, 3'b110: dig = DIG_M1;
      default:        dig = DIG_ZERO;
    endcase
    return dig;
  endfunction

  // Number of Booth digits for a WIDTH-bit operand extended by two bits
  function automatic int unsigned n_dig(input int unsigned width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/pipeline_booth_multiplier_param_if.sv
// Operand/result handshake bundle for pipeline_booth_multiplier_param.
//   in_valid/in_ready, a, b, signed_mode : operand side
//   out_valid/out_ready, product         : result side
// master = producer/consumer environment, slave = multiplier.
interface pipeline_booth_multiplier_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/booth_acc_stage.sv
// One accumulation stage of the Booth pipeline: recodes digit DIG of the
// extended multiplier, adds digit*a << 2*DIG to the running sum and
// registers sum, operands and valid. All registers hold while en=0.
// Ports: clk, rst_n, en, in_* (previous stage), out_* (registered).
module booth_acc_stage
  import pipeline_booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIG   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [WIDTH+1:0]   in_a,
  input  logic [WIDTH+1:0]   in_b,
  input  logic [2*WIDTH+3:0] in_sum,
  output logic               out_valid,
  output logic [WIDTH+1:0]   out_a,
  output logic [WIDTH+1:0]   out_b,
  output logic [2*WIDTH+3:0] out_sum
);
  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned SW    = 2 * WIDTH + 4;
  localparam int unsigned SHIFT = 2 * DIG;

  logic [EW:0]   b_pad_c;
  booth_dig_e    dig_c;
  logic [SW-1:0] a_sx_c;
  logic [SW-1:0] pp_c;
  logic [SW-1:0] pp_sh_c;

  logic          valid_d, valid_q;
  logic [EW-1:0] a_d, a_q;
  logic [EW-1:0] b_d, b_q;
  logic [SW-1:0] sum_d, sum_q;

  // Recode, form the shifted partial product and accumulate
  always_comb begin
    b_pad_c = {in_b, 1'b0};              // appends b[-1] = 0
    dig_c   = booth_recode(b_pad_c[SHIFT+2 -: 3]);
    a_sx_c  = {{(SW-EW){in_a[EW-1]}}, in_a};
    pp_c    = '0;
    case (dig_c)
      DIG_P1:  pp_c = a_sx_c;
      DIG_P2:  pp_c = a_sx_c << 1;
      DIG_M1:  pp_c = -a_sx_c;
      DIG_M2:  pp_c = -(a_sx_c << 1);
      default: pp_c = '0;
    endcase
    pp_sh_c = pp_c << SHIFT;

    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (en) begin
      valid_d = in_valid;
      a_d     = in_a;
      b_d     = in_b;
      sum_d   = in_sum + pp_sh_c;
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_sum   = sum_q;
endmodule

// File: rtl/pipeline_booth_multiplier_param.sv
// Fully pipelined radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
// per-operation signed/unsigned mode, one op per cycle, whole-pipe stall.
// Ports: clk, rst_n (async, active low), bus (slave modport: operand
// handshake in, product handshake out). Latency N_DIG+1 cycles.
module pipeline_booth_multiplier_param
  import pipeline_booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                              clk,
  input logic                              rst_n,
  pipeline_booth_multiplier_param_if.slave bus
);
  localparam int unsigned N_DIG = n_dig(WIDTH);
  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned SW    = 2 * WIDTH + 4;

  logic [N_DIG:0]         valid_pipe;
  logic [N_DIG:0][EW-1:0] a_pipe;
  logic [N_DIG:0][EW-1:0] b_pipe;
  logic [N_DIG:0][SW-1:0] sum_pipe;

  logic          stall_c;
  logic          advance_c;
  logic [EW-1:0] a_ext_c;
  logic [EW-1:0] b_ext_c;

  logic          v0_d, v0_q;
  logic [EW-1:0] a0_d, a0_q;
  logic [EW-1:0] b0_d, b0_q;

  // Any held result freezes every stage, bubbles included
  assign stall_c      = valid_pipe[N_DIG] && !bus.out_ready;
  assign advance_c    = !stall_c;
  assign bus.in_ready = advance_c;

  // Stage 0: extend by two bits so unsigned full-range operands stay exact
  always_comb begin
    a_ext_c = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    b_ext_c = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};
    v0_d    = v0_q;
    a0_d    = a0_q;
    b0_d    = b0_q;
    if (advance_c) begin
      v0_d = bus.in_valid;
      if (bus.in_valid) begin
        a0_d = a_ext_c;
        b0_d = b_ext_c;
      end
    end
  end

  // Stage 0 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      a0_q <= '0;
      b0_q <= '0;
    end else begin
      v0_q <= v0_d;
      a0_q <= a0_d;
      b0_q <= b0_d;
    end
  end

  assign valid_pipe[0] = v0_q;
  assign a_pipe[0]     = a0_q;
  assign b_pipe[0]     = b0_q;
  assign sum_pipe[0]   = '0;

  // Accumulation stages 1..N_DIG
  for (genvar k = 0; k < N_DIG; k++) begin : g_stage
    booth_acc_stage #(
      .WIDTH (WIDTH),
      .DIG   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance_c),
      .in_valid  (valid_pipe[k]),
      .in_a      (a_pipe[k]),
      .in_b      (b_pipe[k]),
      .in_sum    (sum_pipe[k]),
      .out_valid (valid_pipe[k+1]),
      .out_a     (a_pipe[k+1]),
      .out_b     (b_pipe[k+1]),
      .out_sum   (sum_pipe[k+1])
    );
  end

  // Low 2*WIDTH bits of the sum are exact in both modes
  assign bus.out_valid = valid_pipe[N_DIG];
  assign bus.product   = sum_pipe[N_DIG][2*WIDTH-1:0];

  // Last-stage operands and guard bits of the sum have no consumer
  logic unused_tail;
  assign unused_tail = ^{a_pipe[N_DIG], b_pipe[N_DIG], sum_pipe[N_DIG][SW-1:2*WIDTH]};
endmodule

// File: tb/tb_pipeline_booth_multiplier_param.sv
// Self-checking bench for pipeline_booth_multiplier_param at WIDTH 8, 4, 16.
module tb_pipeline_booth_multiplier_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_booth_multiplier_param_if #(.WIDTH(8))  bus8  ();
  pipeline_booth_multiplier_param_if #(.WIDTH(4))  bus4  ();
  pipeline_booth_multiplier_param_if #(.WIDTH(16)) bus16 ();

  pipeline_booth_multiplier_param #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  pipeline_booth_multiplier_param #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  pipeline_booth_multiplier_param #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  int errors = 0;
  int checks = 0;

  logic [31:0] q4[$];
  logic [31:0] q8[$];
  logic [31:0] q16[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sm;
    logic [15:0] exp;
  } vec8_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted by mode
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input bit sm);
    longint span, va, vb, p;
    span = longint'(1) << w;
    va = longint'(a) & (span - 1);
    vb = longint'(b) & (span - 1);
    if (sm && va >= span / 2) va -= span;
    if (sm && vb >= span / 2) vb -= span;
    p = va * vb;
    return 64'(p) & ((64'(1) << (2 * w)) - 1);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (32'(1) << w) - 1;
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'(1) << (w - 1);
      3:       return (32'(1) << (w - 1)) - 1;
      default: return $urandom & m;
    endcase
  endfunction

  function automatic int qsize(input int w);
    case (w)
      4:       return q4.size();
      16:      return q16.size();
      default: return q8.size();
    endcase
  endfunction

  // One cycle: drive at negedge, sample #1 later, score accepts and transfers
  task automatic slot(input int w, input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input bit sm, input bit ordy, output bit ir, output bit ov,
                      output logic [31:0] prod);
    bit          have;
    logic [31:0] exp;
    have = 1'b0;
    exp  = '0;
    @(negedge clk);
    case (w)
      4: begin
        bus4.in_valid = iv; bus4.a = a[3:0]; bus4.b = b[3:0];
        bus4.signed_mode = sm; bus4.out_ready = ordy;
      end
      16: begin
        bus16.in_valid = iv; bus16.a = a[15:0]; bus16.b = b[15:0];
        bus16.signed_mode = sm; bus16.out_ready = ordy;
      end
      default: begin
        bus8.in_valid = iv; bus8.a = a[7:0]; bus8.b = b[7:0];
        bus8.signed_mode = sm; bus8.out_ready = ordy;
      end
    endcase
    #1;
    case (w)
      4:       begin ir = bus4.in_ready;  ov = bus4.out_valid;  prod = 32'(bus4.product);  end
      16:      begin ir = bus16.in_ready; ov = bus16.out_valid; prod = 32'(bus16.product); end
      default: begin ir = bus8.in_ready;  ov = bus8.out_valid;  prod = 32'(bus8.product);  end
    endcase
    if (iv && ir) begin
      exp = 32'(ref_mul(w, a, b, sm));
      case (w)
        4:       q4.push_back(exp);
        16:      q16.push_back(exp);
        default: q8.push_back(exp);
      endcase
    end
    if (ov && ordy) begin
      case (w)
        4:       if (q4.size() > 0)  begin have = 1'b1; exp = q4.pop_front();  end
        16:      if (q16.size() > 0) begin have = 1'b1; exp = q16.pop_front(); end
        default: if (q8.size() > 0)  begin have = 1'b1; exp = q8.pop_front();  end
      endcase
      if (have) check($sformatf("sb_w%0d", w), 64'(prod), 64'(exp));
      else      check($sformatf("sb_w%0d_spurious", w), 64'(ov), 64'd0);
    end
  endtask

  // Single op with no stall; measure cycles until out_valid
  task automatic lat(input int w, input int exp_lat);
    bit          ir, ov;
    logic [31:0] prod;
    int          seen;
    seen = -1;
    slot(w, 1'b1, 32'd3, 32'd2, 1'b1, 1'b1, ir, ov, prod);
    check($sformatf("lat_w%0d_accept", w), 64'(ir), 64'd1);
    for (int s = 1; s <= exp_lat + 4; s++) begin
      slot(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
      if (ov && seen < 0) seen = s;
    end
    check($sformatf("lat_w%0d", w), 64'(seen), 64'(exp_lat));
  endtask

  // Random operands/modes/bubbles/backpressure; source holds until accepted
  task automatic sweep(input int w, input int n);
    bit          ir, ov, pend, sm, ordy;
    logic [31:0] a, b, prod;
    pend = 1'b0; sm = 1'b0; a = '0; b = '0;
    for (int s = 0; s < n; s++) begin
      if (!pend) begin
        a    = pick(w);
        b    = pick(w);
        sm   = 1'($urandom);
        pend = ($urandom_range(0, 3) != 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      slot(w, pend, a, b, sm, ordy, ir, ov, prod);
      if (pend && ir) pend = 1'b0;
    end
    for (int s = 0; s < 40 && qsize(w) > 0; s++)
      slot(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
    check($sformatf("sweep_w%0d_drained", w), 64'(qsize(w)), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec8_t       tbl[8];
    bit          ir, ov, iv, ordy;
    logic [31:0] prod, held, xa, xb;
    logic [31:0] ba[5], bb[5];
    int          starts[5];
    int          idx, got, first, nst, npulse, p0, p1;
    bit          prev_stall;

    tbl[0] = '{8'h02, 8'h04, 1'b1, 16'h0008};
    tbl[1] = '{8'hFC, 8'h05, 1'b1, 16'hFFEC};
    tbl[2] = '{8'h24, 8'hF8, 1'b1, 16'hFEE0};
    tbl[3] = '{8'h81, 8'h81, 1'b1, 16'h3F01};
    tbl[4] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[6] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[7] = '{8'h80, 8'h7F, 1'b1, 16'hC080};

    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.signed_mode = 1'b0;  bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.signed_mode = 1'b0;  bus4.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.signed_mode = 1'b0; bus16.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst_product", 64'(bus8.product), 64'd0);
    check("rst_in_ready", 64'(bus8.in_ready), 64'd1);

    // Back-to-back table vectors: results on consecutive cycles from slot 6
    for (int s = 0; s < 16; s++) begin
      if (s < 8) begin
        slot(8, 1'b1, 32'(tbl[s].a), 32'(tbl[s].b), tbl[s].sm, 1'b1, ir, ov, prod);
        check("tbl_accept", 64'(ir), 64'd1);
      end else begin
        slot(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
      end
      check($sformatf("tbl_valid_slot%0d", s), 64'(ov), 64'(s >= 6 && s < 14));
      if (s >= 6 && s < 14) check($sformatf("tbl_product_%0d", s - 6), 64'(prod), 64'(tbl[s-6].exp));
    end

    // Backpressure: stall 3 cycles after the first result appears
    starts = '{0, 1, 2, 7, 8};
    for (int i = 0; i < 5; i++) begin
      ba[i] = $urandom & 32'hFF;
      bb[i] = $urandom & 32'hFF;
    end
    idx = 0; got = 0; first = -1; nst = 0; prev_stall = 1'b0; held = '0;
    for (int s = 0; s < 40 && got < 5; s++) begin
      ordy = !(first >= 0 && s > first && s <= first + 3);
      iv   = (idx < 5) && (s >= starts[idx < 5 ? idx : 0]);
      xa   = iv ? ba[idx < 5 ? idx : 0] : 32'd0;
      xb   = iv ? bb[idx < 5 ? idx : 0] : 32'd0;
      slot(8, iv, xa, xb, 1'b1, ordy, ir, ov, prod);
      if (iv && ir) idx++;
      if (ov && first < 0) first = s;
      if (ov && ordy) got++;
      if (ov && !ordy) begin
        nst++;
        check("bp_in_ready", 64'(ir), 64'd0);
        if (prev_stall) check("bp_hold", 64'(prod), 64'(held));
        held       = prod;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
    end
    check("bp_results", 64'(got), 64'd5);
    check("bp_stall_cycles", 64'(nst), 64'd3);
    check("bp_queue_empty", 64'(q8.size()), 64'd0);

    // Bubbles: in_valid 1,0,0,1 gives two pulses three cycles apart
    npulse = 0; p0 = -1; p1 = -1;
    for (int s = 0; s < 16; s++) begin
      iv = (s == 0 || s == 3);
      slot(8, iv, 32'd7 + 32'(s), 32'd9, 1'b1, 1'b1, ir, ov, prod);
      if (ov) begin
        if (npulse == 0) p0 = s; else p1 = s;
        npulse++;
      end
    end
    check("bub_pulses", 64'(npulse), 64'd2);
    check("bub_first", 64'(p0), 64'd6);
    check("bub_spacing", 64'(p1 - p0), 64'd3);

    // Reset mid-stream with further ops in flight
    for (int s = 0; s < 5; s++)
      slot(8, 1'b1, pick(8), pick(8), 1'(s), 1'b1, ir, ov, prod);
    slot(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
    slot(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
    check("rstm_pre_valid", 64'(ov), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstm_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rstm_product", 64'(bus8.product), 64'd0);
    check("rstm_in_ready", 64'(bus8.in_ready), 64'd1);
    q4.delete(); q8.delete(); q16.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int s = 0; s < 12; s++) begin
      slot(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
      if (ov) npulse++;
    end
    check("rstm_no_stale", 64'(npulse), 64'd0);
    slot(8, 1'b1, 32'd3, 32'd3, 1'b1, 1'b1, ir, ov, prod);
    for (int s = 1; s <= 6; s++) begin
      slot(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, prod);
      check($sformatf("rstm_new_valid_%0d", s), 64'(ov), 64'(s == 6));
      if (s == 6) check("rstm_new_product", 64'(prod), 64'h0009);
    end

    // Latency and random sweeps for each width
    lat(8, 6);
    lat(4, 4);
    lat(16, 10);
    sweep(8, 400);
    sweep(4, 400);
    sweep(16, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
